// File: rtl/display_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types for the display write arbiter slice.
//   DIGITS      : number of seven-segment digits on the board (fixed at 8)
//   digit_idx_t : digit index, 0 = HEX0
//   bcd_t       : one BCD nibble as stored in the digit register file
//   arb_state_t : arbitration state (OPEN round-robin, LOCKED to one owner)
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int DIGITS = 8;

    typedef logic [2:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/display_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// display_write_arbiter_if
// Bundle between the client blocks and the display write arbiter.
//   clr        : synchronous clear of all digits (beats any write)
//   req        : per-requester write request
//   lock       : per-requester "keep the grant after this write"
//   wr_digit   : per-requester target digit
//   wr_value   : per-requester BCD value
//   wr_blank   : per-requester blank-instead-of-write
//   gnt        : one-hot grant (combinational)
//   bcd        : registered digit values, element i drives BCDi
//   turn_on    : registered digit enables
//   locked     : registered, a lock owner exists
//   owner      : registered lock owner index (0 when unlocked)
//   dbg_state  : registered arbitration state, for observation
//
// Handshake: req[i] is the valid, gnt[i] is the ready. A write transfers on
// a rising edge where req[i] && gnt[i]. A requester keeps req[i] and its
// payload (wr_digit/wr_value/wr_blank/lock) stable until it is granted;
// the payload is only looked at on the transfer edge.
// ---------------------------------------------------------------------------
interface display_write_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import display_pkg::*;

    logic                     clr;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       lock;
    logic [NUM_REQ-1:0][2:0]  wr_digit;
    logic [NUM_REQ-1:0][3:0]  wr_value;
    logic [NUM_REQ-1:0]       wr_blank;
    logic [NUM_REQ-1:0]       gnt;
    bcd_t [DIGITS-1:0]        bcd;
    logic [DIGITS-1:0]        turn_on;
    logic                     locked;
    digit_idx_t               owner;
    arb_state_t               dbg_state;

    // Client side
    modport master (
        output clr, req, lock, wr_digit, wr_value, wr_blank,
        input  gnt, bcd, turn_on, locked, owner, dbg_state
    );

    // Arbiter side
    modport slave (
        input  clr, req, lock, wr_digit, wr_value, wr_blank,
        output gnt, bcd, turn_on, locked, owner, dbg_state
    );

endinterface

// File: rtl/display_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   req       : request vector
//   last      : index of the previous grant; search starts at last+1
//   force_en  : grant only force_idx (if it requests), ignore everyone else
//   force_idx : forced index, used while a lock is held
//   gnt       : one-hot grant, all zero when nothing qualifies
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    input  logic               force_en,
    input  logic [2:0]         force_idx,
    output logic [NUM_REQ-1:0] gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        if (force_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (force_idx == 3'(i)) begin
                    gnt[i] = req[i];
                end
            end
        end else begin
            // Step k = 1..NUM_REQ away from last, wrapping once; the first
            // requester met wins. last < NUM_REQ so one subtraction wraps.
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = int'(last) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && (i == idx) && req[i]) begin
                        gnt[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/display_write_arbiter.sv
// ---------------------------------------------------------------------------
// display_write_arbiter
// Owns the eight-digit BCD register file and turn_on mask of the seven-
// segment display and grants one write per cycle among NUM_REQ clients,
// round-robin, with an optional lock for multi-digit updates.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : display_write_arbiter_if.slave (requests in, grant and display
//           registers out)
// ---------------------------------------------------------------------------
module display_write_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    display_write_arbiter_if.slave bus
);

    arb_state_t          state;
    digit_idx_t          last;
    digit_idx_t          owner_q;
    logic                locked_q;
    bcd_t [DIGITS-1:0]   bcd_q;
    logic [DIGITS-1:0]   on_q;

    logic [NUM_REQ-1:0]  gnt_raw;
    logic [NUM_REQ-1:0]  gnt;
    logic                xfer;
    digit_idx_t          gnt_idx;
    digit_idx_t          sel_digit;
    bcd_t                sel_value;
    logic                sel_blank;
    logic                sel_lock;
    logic                req_owner;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (bus.req),
        .last      (last),
        .force_en  (state == LOCKED),
        .force_idx (owner_q),
        .gnt       (gnt_raw)
    );

    // Reset and clr both suppress the grant so no write can race them.
    always_comb begin
        gnt = (reset || bus.clr) ? '0 : gnt_raw;
    end

    // Collapse the one-hot grant into the granted requester's payload.
    always_comb begin
        gnt_idx   = '0;
        sel_digit = '0;
        sel_value = '0;
        sel_blank = 1'b0;
        sel_lock  = 1'b0;
        req_owner = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx   = 3'(i);
                sel_digit = bus.wr_digit[i];
                sel_value = bus.wr_value[i];
                sel_blank = bus.wr_blank[i];
                sel_lock  = bus.lock[i];
            end
            if (owner_q == 3'(i)) begin
                req_owner = bus.req[i];
            end
        end
    end

    // gnt already implies req, so any grant bit is a transfer.
    assign xfer = |gnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_q    <= '0;
            on_q     <= '0;
            state    <= OPEN;
            owner_q  <= '0;
            locked_q <= 1'b0;
            last     <= 3'(NUM_REQ - 1);
        end else if (bus.clr) begin
            // last is deliberately kept so fairness continues across a clear.
            bcd_q    <= '0;
            on_q     <= '0;
            state    <= OPEN;
            owner_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            if (xfer) begin
                last <= gnt_idx;
                if (sel_blank) begin
                    on_q[sel_digit] <= 1'b0;
                end else begin
                    bcd_q[sel_digit] <= sel_value;
                    on_q[sel_digit]  <= 1'b1;
                end
            end
            case (state)
                OPEN: begin
                    if (xfer && sel_lock) begin
                        state    <= LOCKED;
                        owner_q  <= gnt_idx;
                        locked_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    // While locked, a transfer can only come from the owner.
                    if (!req_owner || (xfer && !sel_lock)) begin
                        state    <= OPEN;
                        owner_q  <= '0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state <= OPEN;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.bcd       = bcd_q;
    assign bus.turn_on   = on_q;
    assign bus.locked    = locked_q;
    assign bus.owner     = owner_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_display_write_arbiter.sv
module tb_display_write_arbiter;
    import display_pkg::*;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    display_write_arbiter_if #(.NUM_REQ(N)) bus ();

    display_write_arbiter #(.NUM_REQ(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Expected order of granted requesters for directed phases.
    logic [2:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_bcd[8];
    bit m_on[8];
    bit m_lk;
    int m_own;
    int m_last;
    bit m_valid = 1'b0;

    // Who must be granted this cycle, -1 for nobody.
    function automatic int model_grant();
        if (reset || bus.clr) return -1;
        if (m_lk) return bus.req[m_own] ? m_own : -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (bus.req[j]) return j;
        end
        return -1;
    endfunction

    // State after the coming rising edge.
    task automatic model_step(input int g);
        bit was_lk;
        was_lk = m_lk;
        if (reset) begin
            for (int d = 0; d < 8; d++) begin m_bcd[d] = 0; m_on[d] = 0; end
            m_lk = 0; m_own = 0; m_last = N - 1;
        end else if (bus.clr) begin
            for (int d = 0; d < 8; d++) begin m_bcd[d] = 0; m_on[d] = 0; end
            m_lk = 0; m_own = 0;
        end else begin
            if (g >= 0) begin
                int d;
                d = int'(bus.wr_digit[g]);
                if (bus.wr_blank[g]) m_on[d] = 0;
                else begin m_bcd[d] = int'(bus.wr_value[g]); m_on[d] = 1; end
                m_last = g;
                if (!was_lk && bus.lock[g]) begin m_lk = 1; m_own = g; end
                else if (was_lk && !bus.lock[g]) begin m_lk = 0; m_own = 0; end
            end else if (was_lk && !bus.req[m_own]) begin
                m_lk = 0; m_own = 0;
            end
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    initial begin
        int          eg;
        logic [31:0] eb;
        logic [31:0] eo;
        logic [31:0] egv;
        logic [2:0]  act_idx;
        forever begin
            @(negedge clock);
            if (m_valid) begin
                eb = '0;
                eo = '0;
                for (int d = 0; d < 8; d++) begin
                    eb[d*4 +: 4] = 4'(m_bcd[d]);
                    eo[d]        = m_on[d];
                end
                chk("cyc_bcd", bus.bcd, eb);
                chk("cyc_turn_on", {24'b0, bus.turn_on}, eo);
                chk("cyc_locked", {31'b0, bus.locked}, {31'b0, m_lk});
                chk("cyc_owner", {29'b0, bus.owner}, 32'(m_own));
            end
            eg  = model_grant();
            egv = (eg < 0) ? 32'd0 : (32'd1 << eg);
            chk("cyc_gnt", {28'b0, bus.gnt}, egv);
            if (|(bus.gnt & bus.req)) begin
                act_idx = '0;
                for (int i = 0; i < N; i++) if (bus.gnt[i]) act_idx = 3'(i);
                if (exp_q.size() > 0) chk("grant_order", {29'b0, act_idx}, {29'b0, exp_q.pop_front()});
            end
            model_step(eg);
            m_valid = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req  = '0;
        bus.lock = '0;
        bus.clr  = 1'b0;
    endtask

    task automatic set_req(input int i, input int d, input int v, input bit blank, input bit lk);
        bus.req[i]      = 1'b1;
        bus.wr_digit[i] = 3'(d);
        bus.wr_value[i] = 4'(v);
        bus.wr_blank[i] = blank;
        bus.lock[i]     = lk;
    endtask

    task automatic chk_gnt(input string name, input logic [3:0] exp);
        @(negedge clock);
        chk(name, {28'b0, bus.gnt}, {28'b0, exp});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bus.clr      = 1'b0;
        bus.req      = '0;
        bus.lock     = '0;
        bus.wr_digit = '0;
        bus.wr_value = '0;
        bus.wr_blank = '0;
        reset        = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset then idle: display dark, no grant.
        tick(); tick();
        chk("rst_bcd", bus.bcd, 32'h0);
        chk("rst_turn_on", {24'b0, bus.turn_on}, 32'h0);
        chk("rst_gnt", {28'b0, bus.gnt}, 32'h0);

        // Write digit 3 = 5, then blank it from another requester.
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd2);
        set_req(0, 3, 5, 1'b0, 1'b0);
        chk_gnt("wr_gnt0", 4'b0001);
        tick();
        bus.req[0] = 1'b0;
        chk("wr_bcd3", {28'b0, bus.bcd[3]}, 32'h5);
        chk("wr_on", {24'b0, bus.turn_on}, 32'h08);
        set_req(2, 3, 0, 1'b1, 1'b0);
        chk_gnt("blank_gnt2", 4'b0100);
        tick();
        bus.req[2] = 1'b0;
        chk("blank_on", {24'b0, bus.turn_on}, 32'h00);
        chk("blank_bcd3", {28'b0, bus.bcd[3]}, 32'h5);

        // All four requesting from reset: 0,1,2,3,0.
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, i, i + 1, 1'b0, 1'b0);
        chk_gnt("rst_blocks_gnt", 4'b0000);
        tick();
        reset = 1'b0;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd0);
        tick(); tick(); tick(); tick();
        chk("rr_bcd", {16'b0, bus.bcd[3:0]}, 32'h4321);
        chk("rr_on", {24'b0, bus.turn_on}, 32'h0F);
        tick();
        idle();
        chk("rr_bcd_again", {16'b0, bus.bcd[3:0]}, 32'h4321);

        // Lock by requester 1 over three writes; 0 and 3 wait.
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd0);
        set_req(1, 0, 7, 1'b0, 1'b1);
        set_req(0, 4, 1, 1'b0, 1'b0);
        set_req(3, 5, 15, 1'b0, 1'b0);
        chk_gnt("lk_gnt_a", 4'b0010);
        tick();
        chk("lk_locked_a", {31'b0, bus.locked}, 32'h1);
        chk("lk_owner_a", {29'b0, bus.owner}, 32'h1);
        set_req(1, 1, 8, 1'b0, 1'b1);
        chk_gnt("lk_gnt_b", 4'b0010);
        tick();
        chk("lk_locked_b", {31'b0, bus.locked}, 32'h1);
        chk("lk_owner_b", {29'b0, bus.owner}, 32'h1);
        set_req(1, 2, 9, 1'b0, 1'b0);
        chk_gnt("lk_gnt_c", 4'b0010);
        tick();
        chk("lk_released", {31'b0, bus.locked}, 32'h0);
        bus.req[1] = 1'b0;
        chk_gnt("lk_next3", 4'b1000);
        tick();
        bus.req[3] = 1'b0;
        chk_gnt("lk_next0", 4'b0001);
        tick();
        bus.req[0] = 1'b0;
        chk("lk_bcd", {20'b0, bus.bcd[2:0]}, 32'h987);
        chk("lk_bcd4", {28'b0, bus.bcd[4]}, 32'h1);
        chk("lk_bcd5_hex", {28'b0, bus.bcd[5]}, 32'hF);
        chk("lk_on", {24'b0, bus.turn_on}, 32'h3F);

        // Lock owner drops req mid-lock: one dead cycle, then OPEN from last+1.
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        set_req(1, 6, 2, 1'b0, 1'b1);
        set_req(2, 7, 6, 1'b0, 1'b0);
        chk_gnt("drop_gnt1", 4'b0010);
        tick();
        chk("drop_locked", {31'b0, bus.locked}, 32'h1);
        bus.req[1] = 1'b0;
        chk_gnt("drop_dead", 4'b0000);
        tick();
        chk("drop_unlocked", {31'b0, bus.locked}, 32'h0);
        chk_gnt("drop_gnt2", 4'b0100);
        tick();
        bus.req[2] = 1'b0;
        chk("drop_bcd76", {24'b0, bus.bcd[7], bus.bcd[6]}, 32'h62);
        chk("drop_on", {24'b0, bus.turn_on}, 32'hFF);

        // clr against a granted write of digit 7 = 9 while locked.
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd0);
        set_req(0, 0, 5, 1'b0, 1'b1);
        chk_gnt("clr_pre_gnt", 4'b0001);
        tick();
        chk("clr_pre_locked", {31'b0, bus.locked}, 32'h1);
        set_req(0, 7, 9, 1'b0, 1'b1);
        bus.clr = 1'b1;
        chk_gnt("clr_gnt", 4'b0000);
        tick();
        bus.clr = 1'b0;
        chk("clr_bcd", bus.bcd, 32'h0);
        chk("clr_on", {24'b0, bus.turn_on}, 32'h0);
        chk("clr_locked", {31'b0, bus.locked}, 32'h0);
        chk("clr_owner", {29'b0, bus.owner}, 32'h0);
        set_req(0, 1, 4, 1'b0, 1'b0);
        chk_gnt("post_clr_gnt", 4'b0001);
        tick();
        chk("post_clr_bcd1", {28'b0, bus.bcd[1]}, 32'h4);
        chk("post_clr_on", {24'b0, bus.turn_on}, 32'h02);

        // Reset mid-lock: lock dropped, no write on the reset edge.
        exp_q.push_back(3'd0);
        set_req(0, 2, 6, 1'b0, 1'b1);
        tick();
        chk("rml_locked", {31'b0, bus.locked}, 32'h1);
        set_req(0, 3, 3, 1'b0, 1'b1);
        reset = 1'b1;
        chk_gnt("rml_gnt", 4'b0000);
        tick();
        reset = 1'b0;
        idle();
        chk("rml_bcd", bus.bcd, 32'h0);
        chk("rml_on", {24'b0, bus.turn_on}, 32'h0);
        chk("rml_locked_after", {31'b0, bus.locked}, 32'h0);
        tick();
        chk_gnt("rml_idle_gnt", 4'b0000);
        tick();

        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_write_arbiter.md
# display_write_arbiter

Shares the eight-digit seven-segment display between several independent requesters. It owns the display's digit register file (eight 4-bit BCD values plus the per-digit `turn_on` enable mask) and grants write access one requester per cycle, using round-robin priority with an optional lock for multi-digit updates. It sits between client blocks (counters, calculators, key handlers) and `SevenSegmentControl`: its `bcd` and `turn_on` outputs drive that module's `BCD7..BCD0` and `turn_on` inputs directly.

## Interface
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `DIGITS`, default 8: number of display digits; fixed at 8 for this board.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous clear of all digits; has priority over any write.
- `req`  in  [NUM_REQ-1:0]  write request, one bit per requester; held until granted.
- `lock`  in  [NUM_REQ-1:0]  requester asks to keep the grant after its current write.
- `wr_digit`  in  [NUM_REQ-1:0][2:0]  target digit index, 0 = HEX0.
- `wr_value`  in  [NUM_REQ-1:0][3:0]  BCD value to write.
- `wr_blank`  in  [NUM_REQ-1:0]  1 = blank the digit instead of writing a value.
- `gnt`  out  [NUM_REQ-1:0]  one-hot grant; combinational from the current state and `req`.
- `bcd`  out  [DIGITS-1:0][3:0]  registered digit values; element i drives BCDi.
- `turn_on`  out  [DIGITS-1:0]  registered digit enables.
- `locked`  out  1  registered; a lock owner currently exists.
- `owner`  out  [2:0]  registered; index of the lock owner, 0 when `locked` is 0.

## Operation
- Transfer: requester i completes a write on a clock edge where `req[i] && gnt[i]`. At most one transfer occurs per cycle.
- Write effect:
  - `wr_blank=0`: `bcd[wr_digit] <= wr_value` and `turn_on[wr_digit] <= 1`.
  - `wr_blank=1`: `turn_on[wr_digit] <= 0`; `bcd[wr_digit]` is unchanged.
- Values 10–15 are stored unmodified. Decoding them is the display driver's job.
- Arbitration has two states.
  - OPEN: the grant goes to the first requesting index found by scanning upward (with wrap) from `last+1`, where `last` is the index of the previous grant. On a transfer by i, `last <= i`. If that transfer has `lock[i]=1`, go to LOCKED with `owner <= i`.
  - LOCKED: `gnt` is one-hot at `owner` when `req[owner]`, otherwise all zero. All other requesters are blocked. Each transfer updates `last <= owner`. Return to OPEN on any cycle where `req[owner]=0`, or where a transfer has `lock[owner]=0`.
  - Leaving LOCKED because `req[owner]` dropped takes effect at the next edge, so the dropped cycle grants nobody.
- `clr`: forces `gnt` to 0 in the same cycle. On the edge, all `bcd` and `turn_on` bits go to 0 and the state returns to OPEN. `last` is unchanged.
- `clr` together with `reset`: `reset` governs; both produce the same result for `bcd` and `turn_on`.
- Reset values:
  - `bcd` all 0, `turn_on` all 0 (display dark).
  - State OPEN, `locked=0`, `owner=0`.
  - `last = NUM_REQ-1`, so requester 0 has first priority.
  - `gnt` is 0 while `reset` is high.
- If `reset` asserts mid-lock, the lock is dropped with no partial write. Data written before the reset edge is lost.

## Timing
- `gnt` is combinational: it is valid in the same cycle as `req`, with no added latency.
- Transfer-to-output latency is 1: `bcd` and `turn_on` change on the edge of the transfer.
- Throughput is one write per cycle, including back-to-back writes by the same requester.
- Fairness: a continuously requesting requester is granted within NUM_REQ-1 other transfers when no locks are taken. Locks can extend this bound without limit; clients must release them.
- `wr_digit`, `wr_value`, `wr_blank` and `lock` are sampled only on transfer edges.
- `locked` and `owner` are registered and reflect the state after the edge.

## Structure
- Package `display_pkg`:
  - `DIGITS = 8`
  - `digit_idx_t` (logic [2:0])
  - `bcd_t` (logic [3:0])
  - `arb_state_t` enum {OPEN, LOCKED}
- Sub-module `rr_arbiter`, parameterized by `NUM_REQ`.
  - Inputs: `req`, `last`, `force_en`, `force_idx`.
  - Output: one-hot `gnt`.
  - Purely combinational. The top level holds `last`, the state and the register file.

## Test plan
- Reset then idle → `bcd` = 0 and `turn_on` = 8'h00 on every digit. `gnt` = 0.
- req0 writes digit 3 = 5, then req2 writes digit 3 with `wr_blank=1` → one cycle after the first transfer, `bcd[3]`=5 and `turn_on`=8'h08. One cycle after the second, `turn_on`=8'h00 and `bcd[3]` is still 5.
- All four requesters held high from reset → grants 0,1,2,3,0 on consecutive cycles. Digits 0..3 written with values 1..4 give `bcd[3:0]` = {4,3,2,1} and `turn_on`=8'h0F.
- req1 locks while writing digits 0,1,2 (lock=1,1,0) with req0 and req3 high throughout → `gnt`=4'b0010 for three cycles and `locked`=1, `owner`=1 in between. The next grant goes to 3, then 0.
- Lock owner drops `req` mid-lock → one cycle with `gnt`=0, then OPEN arbitration resumes from `last+1`.
- `clr` asserted in the same cycle as a granted write of digit 7 = 9 → `gnt`=0 that cycle, no write occurs, all digits are cleared and `locked`=0 afterwards.
